// File: rtl/se_sram_pkg.sv
// Shared definitions for the se_sram family: clear-sequencer state type
// and the legal range of the read pipeline latency.
package se_sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

endpackage

// File: rtl/se_sram_clear_seq.sv
// Post-reset zero-fill sequencer for the SRAM array; compiled in only when
// SE_SRAM_CLEAR_EN is defined, otherwise it reports never busy.
module se_sram_clear_seq
  import se_sram_pkg::*;
#(
  parameter int address_width = 10
) (
  input  logic                     sram_clock,
  input  logic                     reset_n,
  input  logic                     sram_clock__enable,
  output logic                     busy,
  output logic                     clear_we,
  output logic [address_width-1:0] clear_addr
);

`ifdef SE_SRAM_CLEAR_EN
  clear_state_t             state;
  logic [address_width-1:0] count;

  // One word per enabled cycle; the last address is written on the way to READY.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      count <= '0;
      busy  <= 1'b1;
    end else if (sram_clock__enable && state == CLEAR) begin
      count <= count + address_width'(1);
      if (count == '1) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  assign clear_we   = busy & sram_clock__enable;
  assign clear_addr = count;
`else
  logic unused_clear_inputs;
  assign unused_clear_inputs = &{1'b0, sram_clock, reset_n, sram_clock__enable};

  assign busy       = 1'b0;
  assign clear_we   = 1'b0;
  assign clear_addr = '0;
`endif

endmodule

// File: rtl/se_sram_srw_be_pipe.sv
// Single-port SRAM with per-byte write enables and a 1- or 2-stage read pipeline.
// Define SE_SRAM_CLEAR_EN to zero-fill the array after reset (busy while clearing).
module se_sram_srw_be_pipe
  import se_sram_pkg::*;
#(
  parameter int    address_width = 10,
  parameter int    data_width    = 32,
  parameter int    byte_width    = 8,
  parameter int    read_latency  = 1,
  parameter string initfile      = ""
) (
  input  logic                               sram_clock,
  input  logic                               reset_n,
  input  logic                               sram_clock__enable,
  input  logic                               select,
  input  logic                               read_not_write,
  input  logic [data_width/byte_width-1:0]   write_enable,
  input  logic [address_width-1:0]           address,
  input  logic [data_width-1:0]              write_data,
  output logic [data_width-1:0]              data_out,
  output logic                               data_out_valid,
  output logic                               busy
);

  localparam int num_bytes = data_width / byte_width;
  localparam int depth     = 1 << address_width;
  localparam bit unused_initfile = (initfile == "");

  if ((data_width % byte_width) != 0) begin : g_bad_byte_width
    $error("se_sram_srw_be_pipe: data_width must be a multiple of byte_width");
  end
  if (read_latency < READ_LATENCY_MIN || read_latency > READ_LATENCY_MAX) begin : g_bad_latency
    $error("se_sram_srw_be_pipe: read_latency must be 1 or 2");
  end

  logic                     clear_we;
  logic [address_width-1:0] clear_addr;

  se_sram_clear_seq #(
    .address_width(address_width)
  ) u_clear_seq (
    .sram_clock        (sram_clock),
    .reset_n           (reset_n),
    .sram_clock__enable(sram_clock__enable),
    .busy              (busy),
    .clear_we          (clear_we),
    .clear_addr        (clear_addr)
  );

  logic vld_p0;
  logic wr_p0;
  assign vld_p0 = sram_clock__enable & select & ~busy & read_not_write;
  assign wr_p0  = sram_clock__enable & select & ~busy & ~read_not_write;

  (* ram_init_file = initfile *)
  logic [data_width-1:0] mem [depth];

  // Clear writes take priority; user requests are already blocked while busy.
  always_ff @(posedge sram_clock) begin
    if (clear_we) begin
      mem[clear_addr] <= '0;
    end else if (wr_p0) begin
      for (int b = 0; b < num_bytes; b++) begin
        if (write_enable[b]) begin
          mem[address][b*byte_width +: byte_width] <= write_data[b*byte_width +: byte_width];
        end
      end
    end
  end

  logic                  res_vld;
  logic [data_width-1:0] res_data;

  if (read_latency == 2) begin : g_lat2
    logic                  vld_p1;
    logic [data_width-1:0] data_p1;

    // p0 -> p1: registered array read
    always_ff @(posedge sram_clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_p1 <= 1'b0;
      end else if (sram_clock__enable) begin
        vld_p1 <= vld_p0;
      end
    end

    always_ff @(posedge sram_clock) begin
      if (vld_p0) begin
        data_p1 <= mem[address];
      end
    end

    assign res_vld  = vld_p1;
    assign res_data = data_p1;
  end else begin : g_lat1
    assign res_vld  = vld_p0;
    assign res_data = mem[address];
  end

  // Output stage: holds the last read word, valid pulses for one enabled cycle.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (sram_clock__enable) begin
      data_out_valid <= res_vld;
      if (res_vld) begin
        data_out <= res_data;
      end
    end
  end

endmodule

// File: doc/se_sram_srw_be_pipe.md
SE_SRAM_SRW_BE_PIPE -- requirements
Module: se_sram_srw_be_pipe

Interface
REQ-001 SHALL provide parameter address_width, default 10, address bits; depth is 1<<address_width words.
REQ-002 SHALL provide parameter data_width, default 32, word width in bits.
REQ-003 SHALL provide parameter byte_width, default 8, write-enable granularity; data_width not a multiple of byte_width SHALL be an elaboration error.
REQ-004 SHALL provide parameter read_latency, default 1, legal 1 or 2, cycles from accepted read to data_out_valid; other values SHALL be an elaboration error.
REQ-005 SHALL provide parameter initfile, default "", memory init file attached to the array.
REQ-006 sram_clock  in  1  single clock; all state updates on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 sram_clock__enable  in  1  global stall; low freezes all state including pipeline and clear counter.
REQ-009 select  in  1  request valid.
REQ-010 read_not_write  in  1  1 = read, 0 = write.
REQ-011 write_enable  in  data_width/byte_width  per-byte write mask; bit i covers write_data[i*byte_width +: byte_width].
REQ-012 address  in  address_width  word address.
REQ-013 write_data  in  data_width  write data.
REQ-014 data_out  out  data_width  read data; holds last read value until next read completes.
REQ-015 data_out_valid  out  1  single-cycle pulse when data_out updated by a read.
REQ-016 busy  out  1  high while clear sequence runs; requests ignored.

Function
REQ-017 Request accepted on a rising edge with sram_clock__enable=1, select=1, busy=0.
REQ-018 Accepted write SHALL update only bytes whose write_enable bit is 1; write_enable all-zero SHALL leave memory unchanged.
REQ-019 Accepted read SHALL load data_out and pulse data_out_valid exactly read_latency enabled cycles after acceptance.
REQ-020 read_latency=2 SHALL add one output register stage; back-to-back reads SHALL sustain one result per enabled cycle in order.
REQ-021 Write then read of same address on next cycle SHALL return the written data (no hazard); read and write never in one cycle (single port).
REQ-022 Enabled cycles without a completing read SHALL drive data_out_valid=0 and hold data_out.
REQ-023 Cycles with sram_clock__enable=0 SHALL not count toward latency; data_out_valid SHALL remain at its prior value and pipeline contents SHALL be preserved.
REQ-024 Read pipeline SHALL continue draining while busy is high (no in-flight read lost).

Reset
REQ-025 Reset SHALL force data_out=0, data_out_valid=0, pipeline valid bits=0, clear state per REQ-028; memory array contents are not reset.
REQ-026 Reset asserted mid-read SHALL discard the in-flight read; no data_out_valid after reset release.

Configuration
REQ-027 Macro SE_SRAM_CLEAR_EN SHALL compile in a zero-fill sequencer; absent, busy SHALL be constant 0 and memory holds initfile/undefined contents.
REQ-028 With SE_SRAM_CLEAR_EN: states CLEAR and READY; reset enters CLEAR with counter 0; each enabled cycle writes all-zero word to counter address and increments; at counter = depth-1 write then go READY; busy=1 exactly in CLEAR.
REQ-029 With SE_SRAM_CLEAR_EN, reset during CLEAR SHALL restart from address 0; clear takes exactly depth enabled cycles.

Structure
REQ-030 Shared package se_sram_pkg SHALL hold the clear-state enum type and read_latency limit constants (min 1, max 2).
REQ-031 Clear sequencer SHALL be sub-module se_sram_clear_seq (counter, state, busy, clear address/write strobe); array and read pipeline stay in top.

Verification
REQ-032 Width 32, byte 8: write 0xAABBCCDD mask 4'b1111 addr 5, then mask 4'b0010 data 0x00001100 -> read addr 5 returns 0xAABB11DD.
REQ-033 read_latency=2: reads addr 1,2,3 back-to-back holding 0x11,0x22,0x33 -> valid pulses on cycles 2,3,4 with data in order.
REQ-034 Read accepted, sram_clock__enable low 3 cycles -> data_out_valid delayed exactly 3 cycles, data unchanged.
REQ-035 SE_SRAM_CLEAR_EN, address_width=4: release reset -> busy high exactly 16 enabled cycles; write during busy ignored; all 16 reads return 0.
REQ-036 Assert reset_n low during read pipeline and at clear counter 7 -> data_out=0, valid=0 immediately; clear restarts, busy 16 cycles.
